// File: rtl/decim_ctrl_pkg.sv
// Shared types and constants for the decimation conversion sequencer.
package decim_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SETTLE,
        S_ACQ,
        S_DONE
    } state_t;

    // Number of cycles the decimation chain is held in clear.
    localparam int CLR_CYCLES = 2;

    // Accumulator width: sample width plus headroom for 2^navg_log2 additions.
    function automatic int acc_width(input int width, input int frac, input int navg_log2);
        return width + frac + navg_log2;
    endfunction

endpackage

// File: rtl/decim_avg_acc.sv
// Averaging datapath: clears, accumulates sign-extended FIR samples and
// produces the floored mean of 2^NAVG_LOG2 samples on the last one.
module decim_avg_acc
    import decim_ctrl_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int FRAC      = 8,
    parameter int NAVG_LOG2 = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clr,
    input  logic                          add,
    input  logic                          last,
    input  logic signed [WIDTH+FRAC-1:0]  din,
    output logic signed [WIDTH+FRAC-1:0]  result
);

    localparam int DW    = WIDTH + FRAC;
    localparam int ACC_W = acc_width(WIDTH, FRAC, NAVG_LOG2);

    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] din_ext;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] sum_sh;

    // Sign-extend the incoming sample, add it, and floor-divide by 2^NAVG_LOG2.
    assign din_ext = ACC_W'(din);
    assign sum     = acc_q + din_ext;
    assign sum_sh  = sum >>> NAVG_LOG2;

    // Accumulator and result register; result holds until the next final sample.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q  <= '0;
            result <= '0;
        end else if (clr) begin
            acc_q <= '0;
        end else if (add) begin
            if (last) begin
                result <= sum_sh[DW-1:0];
                acc_q  <= '0;
            end else begin
                acc_q <= sum;
            end
        end
    end

endmodule

// File: rtl/decim_conv_ctrl.sv
// Conversion sequencer for the CIC/FIR decimation chain: clears and enables
// the chain, discards the FIR settling transient, averages 2^NAVG_LOG2 FIR
// outputs and presents one result on a valid/ready interface.
// Optional watchdog enabled by defining DECIM_CTRL_TIMEOUT_EN (adds timeout_err).
module decim_conv_ctrl
    import decim_ctrl_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int FRAC      = 8,
    parameter int SETTLE    = 4,
    parameter int NAVG_LOG2 = 2,
    parameter int TIMEOUT   = 4100
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          abort,
    output logic                          busy,
    output logic                          chain_clr,
    output logic                          chain_en,
    input  logic signed [WIDTH+FRAC-1:0]  fir_out,
    input  logic                          fir_valid,
    output logic signed [WIDTH+FRAC-1:0]  result,
    output logic                          result_valid,
    input  logic                          result_ready
`ifdef DECIM_CTRL_TIMEOUT_EN
    ,
    output logic                          timeout_err
`endif
);

    // Sample counter covers up to 255 settle strobes or 256 averaged strobes.
    localparam logic [8:0] SETTLE_LAST = 9'(SETTLE - 1);
    localparam logic [8:0] NAVG_LAST   = 9'((1 << NAVG_LOG2) - 1);
    localparam logic [1:0] CLR_LAST    = 2'(CLR_CYCLES - 1);

    state_t     state_q, state_nx;
    logic [8:0] cnt_q, cnt_nx;
    logic [1:0] clr_cnt_q, clr_cnt_nx;
    logic       start_acc;
    logic       timeout_set;
    logic       timeout_hit;
    logic       acc_clr, acc_add, acc_last;

`ifdef DECIM_CTRL_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_q;
    logic            running;

    assign running     = (state_q == S_SETTLE) || (state_q == S_ACQ);
    assign timeout_hit = running && (wd_q == WD_W'(TIMEOUT - 1));

    // Watchdog: counts cycles since entering SETTLE/ACQ or since the last strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_q <= '0;
        end else if (!running || fir_valid) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_q + 1'b1;
        end
    end

    // Sticky timeout flag, cleared when the next conversion is accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timeout_err <= 1'b0;
        end else if (timeout_set) begin
            timeout_err <= 1'b1;
        end else if (start_acc) begin
            timeout_err <= 1'b0;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // State and counter registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_nx;
            cnt_q     <= cnt_nx;
            clr_cnt_q <= clr_cnt_nx;
        end
    end

    // Next-state, counter and datapath-control decode.
    always_comb begin
        // NOTE: every output of this block is defaulted first so no path
        // leaves a signal unassigned, which would infer a latch.
        state_nx    = state_q;
        cnt_nx      = cnt_q;
        clr_cnt_nx  = clr_cnt_q;
        start_acc   = 1'b0;
        timeout_set = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_nx   = S_CLEAR;
                    start_acc  = 1'b1;
                    clr_cnt_nx = '0;
                    cnt_nx     = '0;
                end
            end
            S_CLEAR: begin
                cnt_nx = '0;
                if (clr_cnt_q == CLR_LAST) begin
                    state_nx = S_SETTLE;
                end else begin
                    clr_cnt_nx = clr_cnt_q + 1'b1;
                end
            end
            S_SETTLE: begin
                if (fir_valid) begin
                    if (cnt_q == SETTLE_LAST) begin
                        cnt_nx   = '0;
                        state_nx = S_ACQ;
                    end else begin
                        cnt_nx = cnt_q + 1'b1;
                    end
                end else if (timeout_hit) begin
                    state_nx    = S_IDLE;
                    timeout_set = 1'b1;
                end
            end
            S_ACQ: begin
                if (fir_valid) begin
                    if (cnt_q == NAVG_LAST) begin
                        cnt_nx   = '0;
                        state_nx = S_DONE;
                    end else begin
                        cnt_nx = cnt_q + 1'b1;
                    end
                end else if (timeout_hit) begin
                    state_nx    = S_IDLE;
                    timeout_set = 1'b1;
                end
            end
            S_DONE: begin
                if (result_ready) begin
                    if (start) begin
                        state_nx   = S_CLEAR;
                        start_acc  = 1'b1;
                        clr_cnt_nx = '0;
                        cnt_nx     = '0;
                    end else begin
                        state_nx = S_IDLE;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase

        // Abort overrides everything else in any active state.
        if (abort && (state_q != S_IDLE)) begin
            state_nx    = S_IDLE;
            start_acc   = 1'b0;
            timeout_set = 1'b0;
        end
    end

    assign acc_clr  = (state_q == S_CLEAR);
    assign acc_add  = (state_q == S_ACQ) && fir_valid && !abort;
    assign acc_last = (cnt_q == NAVG_LAST);

    // Registered outputs decoded from the upcoming state so they align with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy         <= 1'b0;
            chain_clr    <= 1'b0;
            chain_en     <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            busy         <= (state_nx != S_IDLE);
            chain_clr    <= (state_nx == S_CLEAR);
            chain_en     <= (state_nx == S_SETTLE) || (state_nx == S_ACQ);
            result_valid <= (state_nx == S_DONE);
        end
    end

    decim_avg_acc #(
        .WIDTH    (WIDTH),
        .FRAC     (FRAC),
        .NAVG_LOG2(NAVG_LOG2)
    ) u_acc (
        .clk   (clk),
        .reset (reset),
        .clr   (acc_clr),
        .add   (acc_add),
        .last  (acc_last),
        .din   (fir_out),
        .result(result)
    );

endmodule

// File: doc/decim_conv_ctrl.md
# decim_conv_ctrl

Conversion sequencer for the delta-sigma decimation chain (2-stage CIC integrator/comb with downsampler, followed by the 128-tap FIR). On a start request it clears the chain and enables it. It discards the FIR settling transient, averages a power-of-two number of FIR outputs, and presents one result on a valid/ready interface. It sits between the system control logic and the decimation datapath, driving that datapath's clear and enable.

## Interface
- WIDTH, 32, CIC/FIR integer width; must match the chain
- FRAC, 8, FIR fractional bits; data width is WIDTH+FRAC
- SETTLE, 4, number of FIR outputs discarded after clear (1..255)
- NAVG_LOG2, 2, log2 of the number of averaged FIR outputs (0..8)
- TIMEOUT, 4100, watchdog limit in clk cycles (used only with the macro)
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- start  in  1  conversion request; sampled only in IDLE, and in DONE during a result handshake
- abort  in  1  cancels any conversion; returns to IDLE
- busy  out  1  high in every state except IDLE
- chain_clr  out  1  synchronous clear to the decimation chain
- chain_en  out  1  enable to the modulator bitstream and the decimation chain
- fir_out  in  WIDTH+FRAC  signed FIR sample, Q(WIDTH).FRAC
- fir_valid  in  1  one-cycle strobe qualifying fir_out
- result  out  WIDTH+FRAC  signed averaged sample
- result_valid  out  1  result available
- result_ready  in  1  consumer accepts result
- timeout_err  out  1  sticky watchdog flag (present only with the macro)

## Operation
- FSM states: IDLE, CLEAR, SETTLE, ACQ, DONE.
- IDLE: start=1 -> CLEAR. chain_en=0, chain_clr=0.
- CLEAR: chain_clr=1, chain_en=0 for exactly CLR_CYCLES=2 cycles, then SETTLE. The sample counter and accumulator are zeroed.
- SETTLE: chain_en=1. Each fir_valid increments the counter. On the SETTLE-th strobe, the counter is zeroed and the FSM moves to ACQ. Discarded samples are never accumulated.
- ACQ: chain_en=1. Each fir_valid adds sign-extended fir_out to an accumulator of width WIDTH+FRAC+NAVG_LOG2. On the 2^NAVG_LOG2-th strobe:
  - result <= (acc + fir_out) >>> NAVG_LOG2, using an arithmetic shift that floors toward minus infinity.
  - The FSM moves to DONE.
- DONE: chain_en=0. result_valid=1, and result holds stable until result_ready=1.
  - result_ready=1 and start=0 -> IDLE.
  - result_ready=1 and start=1 -> CLEAR (back-to-back conversion).
- abort=1 in any non-IDLE state -> IDLE on the next edge.
  - result_valid, chain_clr and chain_en drop; result keeps its last value.
  - abort has priority over fir_valid, start and result_ready in the same cycle.
- start while busy, outside the DONE handshake, is ignored and not queued.
- fir_valid in IDLE, CLEAR or DONE is ignored.

## Timing
- Reset values: state=IDLE, busy=0, chain_clr=0, chain_en=0, result=0, result_valid=0, timeout_err=0.
- All outputs are registered.
- Start latency, with start sampled at edge t:
  - busy=1 and chain_clr=1 from t+1 through t+2.
  - chain_en=1 from t+3.
- The result edge is the edge that samples the final ACQ fir_valid. result_valid=1 and chain_en=0 are visible in the cycle after it.
- Handshake: the transfer occurs on the edge where result_valid=1 and result_ready=1. result_valid=0 in the following cycle, unless the FSM goes back-to-back.
- Total conversion length is (SETTLE + 2^NAVG_LOG2) FIR strobes + 3 cycles. Each FIR strobe is about OSR cycles apart.

## Configuration
- Macro: DECIM_CTRL_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in SETTLE and ACQ, reset on entry and on every fir_valid.
  - Reaching TIMEOUT -> IDLE with chain_en=0 and timeout_err=1.
  - timeout_err clears when the next start is accepted.
  - abort has priority over a timeout in the same cycle.
- Undefined: no counter and no timeout_err port. The FSM waits on fir_valid indefinitely.

## Structure
- Package decim_ctrl_pkg holds:
  - the state enum;
  - CLR_CYCLES=2;
  - a function returning the accumulator width, WIDTH+FRAC+NAVG_LOG2.
- One sub-module, decim_avg_acc, containing the clear, accumulate and shift-out datapath. The FSM stays in decim_conv_ctrl.

## Test plan
All scenarios use SETTLE=4 and NAVG_LOG2=2.
- Reset low mid-ACQ -> all outputs 0 immediately. After release, IDLE and busy=0.
- Start, then 4 discarded strobes, then fir_out raw values 100, 200, 300, 404 -> result=251 and result_valid=1 the cycle after the 8th strobe. chain_clr is high exactly 2 cycles.
- Negative data: raw values -1, -1, -1, -2 -> result=-2 (floor). Hold result_ready=0 for 5 cycles -> result stable. Then ready=1 with start=1 -> immediate CLEAR.
- abort in the same cycle as the 3rd ACQ fir_valid -> IDLE, no result_valid. Start pulses during SETTLE are ignored.
- Macro defined, TIMEOUT=50, stop fir_valid in ACQ -> IDLE after 50 cycles with timeout_err=1. The next accepted start clears it.
